// File: rtl/pipe_pkg.sv
// Shared pipeline-control constants: register address width, forwarding
// select encodings and hazard FSM state encodings.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FWD_SEL_W  = 2;

  localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM     = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_WB      = 2'd2;

  localparam logic [1:0] HZ_IDLE  = 2'd0;
  localparam logic [1:0] HZ_STALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH = 2'd2;

  // r0 is hardwired zero, so it never takes part in a dependency
  function automatic logic addr_match(input logic [REG_ADDR_W-1:0] a,
                                      input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source select for one EX-stage operand; MEM result beats WB data.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src_addr,
  input  logic                  i_mem_we,
  input  logic [REG_ADDR_W-1:0] i_mem_addr,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  output logic [FWD_SEL_W-1:0]  o_sel
);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (i_mem_we && addr_match(i_mem_addr, i_src_addr)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_we && addr_match(i_wb_addr, i_src_addr)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, branch flush sequencing,
// EX operand forwarding selects and saturating stall/flush event counters.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_ra_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_ra,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
  input  logic                  ex_do_reg_write,
  input  logic                  ex_do_dm_read,
  input  logic [REG_ADDR_W-1:0] ex_ra_addr,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic [REG_ADDR_W-1:0] mem_write_reg_addr,
  input  logic                  mem_do_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg_addr,
  input  logic                  wb_do_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  cnt_clear,
  output logic                  do_hazard,
  output logic                  do_flush_REG1,
  output logic [FWD_SEL_W-1:0]  fwd_ra_sel,
  output logic [FWD_SEL_W-1:0]  fwd_rt_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned       FCNT_W    = 2;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the combinational branch term
  localparam logic [1:0]        BR_NEXT   = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_IDLE;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;
  logic              w_load_use;
  logic              w_flush;
  logic              w_hazard;

  fwd_select u_fwd_ra (
    .i_src_addr (ex_ra_addr),
    .i_mem_we   (mem_do_reg_write),
    .i_mem_addr (mem_write_reg_addr),
    .i_wb_we    (wb_do_reg_write),
    .i_wb_addr  (wb_write_reg_addr),
    .o_sel      (fwd_ra_sel)
  );

  fwd_select u_fwd_rt (
    .i_src_addr (ex_rt_addr),
    .i_mem_we   (mem_do_reg_write),
    .i_mem_addr (mem_write_reg_addr),
    .i_wb_we    (wb_do_reg_write),
    .i_wb_addr  (wb_write_reg_addr),
    .o_sel      (fwd_rt_sel)
  );

  always_comb begin
    w_load_use = ex_do_dm_read && ex_do_reg_write &&
                 ((id_uses_ra && addr_match(ex_write_reg_addr, id_ra_addr)) ||
                  (id_uses_rt && addr_match(ex_write_reg_addr, id_rt_addr)));
    w_flush    = ex_branch_taken || (r_state == HZ_FLUSH);
    // The REG1 instruction is on the wrong path when flushing, so never stall it
    w_hazard   = w_load_use && (r_state == HZ_IDLE) && !w_flush;
  end

  assign do_hazard     = w_hazard;
  assign do_flush_REG1 = w_flush;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (ex_branch_taken) begin
      w_state_nxt = BR_NEXT;
      w_fcnt_nxt  = FCNT_LOAD;
    end else begin
      case (r_state)
        HZ_IDLE: begin
          if (w_load_use) w_state_nxt = HZ_STALL;
        end
        HZ_STALL: begin
          w_state_nxt = HZ_IDLE;
        end
        HZ_FLUSH: begin
          if (r_fcnt <= FCNT_W'(1)) begin
            w_state_nxt = HZ_IDLE;
            w_fcnt_nxt  = '0;
          end else begin
            w_fcnt_nxt  = r_fcnt - FCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = HZ_IDLE;
          w_fcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= HZ_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Event counters: clear beats increment, both saturate at all-ones
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (cnt_clear) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_hazard && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (2- and 3-cycle flush, and a
// 1-cycle flush with 2-bit counters for saturation) share one stimulus.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_ra_addr, id_rt_addr, ex_write_reg_addr, ex_ra_addr, ex_rt_addr;
  logic [4:0] mem_write_reg_addr, wb_write_reg_addr;
  logic       id_uses_ra, id_uses_rt, ex_do_reg_write, ex_do_dm_read;
  logic       mem_do_reg_write, wb_do_reg_write, ex_branch_taken, cnt_clear;

  logic        a_hz, a_fl, b_hz, b_fl, c_hz, c_fl;
  logic [1:0]  a_rsel, a_tsel, b_rsel, b_tsel, c_rsel, c_tsel;
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [1:0]  c_scnt, c_fcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .id_ra_addr(id_ra_addr), .id_rt_addr(id_rt_addr),
    .id_uses_ra(id_uses_ra), .id_uses_rt(id_uses_rt), .ex_write_reg_addr(ex_write_reg_addr),
    .ex_do_reg_write(ex_do_reg_write), .ex_do_dm_read(ex_do_dm_read), .ex_ra_addr(ex_ra_addr),
    .ex_rt_addr(ex_rt_addr), .mem_write_reg_addr(mem_write_reg_addr),
    .mem_do_reg_write(mem_do_reg_write), .wb_write_reg_addr(wb_write_reg_addr),
    .wb_do_reg_write(wb_do_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .do_hazard(a_hz), .do_flush_REG1(a_fl), .fwd_ra_sel(a_rsel), .fwd_rt_sel(a_tsel),
    .stall_count(a_scnt), .flush_count(a_fcnt));

  hazard_unit #(.FLUSH_CYCLES(3), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .id_ra_addr(id_ra_addr), .id_rt_addr(id_rt_addr),
    .id_uses_ra(id_uses_ra), .id_uses_rt(id_uses_rt), .ex_write_reg_addr(ex_write_reg_addr),
    .ex_do_reg_write(ex_do_reg_write), .ex_do_dm_read(ex_do_dm_read), .ex_ra_addr(ex_ra_addr),
    .ex_rt_addr(ex_rt_addr), .mem_write_reg_addr(mem_write_reg_addr),
    .mem_do_reg_write(mem_do_reg_write), .wb_write_reg_addr(wb_write_reg_addr),
    .wb_do_reg_write(wb_do_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .do_hazard(b_hz), .do_flush_REG1(b_fl), .fwd_ra_sel(b_rsel), .fwd_rt_sel(b_tsel),
    .stall_count(b_scnt), .flush_count(b_fcnt));

  hazard_unit #(.FLUSH_CYCLES(1), .CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .id_ra_addr(id_ra_addr), .id_rt_addr(id_rt_addr),
    .id_uses_ra(id_uses_ra), .id_uses_rt(id_uses_rt), .ex_write_reg_addr(ex_write_reg_addr),
    .ex_do_reg_write(ex_do_reg_write), .ex_do_dm_read(ex_do_dm_read), .ex_ra_addr(ex_ra_addr),
    .ex_rt_addr(ex_rt_addr), .mem_write_reg_addr(mem_write_reg_addr),
    .mem_do_reg_write(mem_do_reg_write), .wb_write_reg_addr(wb_write_reg_addr),
    .wb_do_reg_write(wb_do_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .do_hazard(c_hz), .do_flush_REG1(c_fl), .fwd_ra_sel(c_rsel), .fwd_rt_sel(c_tsel),
    .stall_count(c_scnt), .flush_count(c_fcnt));

  typedef struct {
    logic [4:0] ex_ra;
    logic [4:0] ex_rt;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic [4:0] wb_addr;
    logic       wb_we;
    logic [1:0] exp_ra;
    logic [1:0] exp_rt;
  } fwd_vec_t;

  fwd_vec_t fv[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the active (falling) edge; outputs sampled at the rising edge
  task automatic next_cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic set_lu(input logic on, input logic [4:0] addr);
    ex_do_dm_read     = on;
    ex_do_reg_write   = on;
    ex_write_reg_addr = addr;
    id_rt_addr        = addr;
    id_uses_rt        = on;
    id_ra_addr        = 5'd0;
    id_uses_ra        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic brs[5];
    logic expa[5];
    logic expb[5];
    logic expc[5];

    fv[0] = '{5'd3,  5'd7,  5'd3,  1'b1, 5'd3,  1'b1, 2'd1, 2'd0};
    fv[1] = '{5'd3,  5'd7,  5'd3,  1'b0, 5'd3,  1'b1, 2'd2, 2'd0};
    fv[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'd0, 2'd0};
    fv[3] = '{5'd4,  5'd9,  5'd9,  1'b1, 5'd4,  1'b1, 2'd2, 2'd1};
    fv[4] = '{5'd5,  5'd5,  5'd5,  1'b0, 5'd5,  1'b0, 2'd0, 2'd0};
    fv[5] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1, 2'd2, 2'd1};
    fv[6] = '{5'd12, 5'd12, 5'd12, 1'b1, 5'd12, 1'b0, 2'd1, 2'd1};
    fv[7] = '{5'd8,  5'd17, 5'd17, 1'b1, 5'd17, 1'b1, 2'd0, 2'd1};

    reset = 1'b0;
    ex_ra_addr = '0; ex_rt_addr = '0; mem_write_reg_addr = '0; mem_do_reg_write = 1'b0;
    wb_write_reg_addr = '0; wb_do_reg_write = 1'b0; ex_branch_taken = 1'b0; cnt_clear = 1'b0;
    set_lu(1'b0, 5'd0);

    // Reset: branch passes straight through, but no state or count is kept
    next_cyc();
    ex_branch_taken = 1'b1;
    @(posedge clock);
    chk("rst_flush_comb", int'(a_fl), 1);
    next_cyc();
    ex_branch_taken = 1'b0;
    @(posedge clock);
    chk("rst_flush_no_state", int'(a_fl), 0);
    chk("rst_flush_cnt", int'(a_fcnt), 0);
    chk("rst_stall_cnt", int'(a_scnt), 0);
    chk("rst_hazard", int'(a_hz), 0);
    next_cyc();
    reset = 1'b1;

    // Forwarding table
    for (int i = 0; i < 8; i++) begin
      ex_ra_addr = fv[i].ex_ra; ex_rt_addr = fv[i].ex_rt;
      mem_write_reg_addr = fv[i].mem_addr; mem_do_reg_write = fv[i].mem_we;
      wb_write_reg_addr = fv[i].wb_addr; wb_do_reg_write = fv[i].wb_we;
      @(posedge clock);
      chk($sformatf("fwd_ra[%0d]", i), int'(a_rsel), int'(fv[i].exp_ra));
      chk($sformatf("fwd_rt[%0d]", i), int'(a_tsel), int'(fv[i].exp_rt));
      next_cyc();
    end

    // Load-use on rt=r5: one stall cycle, then STALL state suppresses do_hazard
    set_lu(1'b1, 5'd5);
    @(posedge clock);
    chk("lu_hazard", int'(a_hz), 1);
    chk("lu_no_flush", int'(a_fl), 0);
    next_cyc();
    chk("lu_stall_cnt", int'(a_scnt), 1);
    @(posedge clock);
    chk("lu_stall_state_hz", int'(a_hz), 0);
    next_cyc();
    set_lu(1'b0, 5'd0);
    chk("lu_stall_cnt_hold", int'(a_scnt), 1);

    // Load into r0 never stalls
    ex_do_dm_read = 1'b1; ex_do_reg_write = 1'b1; ex_write_reg_addr = 5'd0;
    id_ra_addr = 5'd0; id_uses_ra = 1'b1;
    @(posedge clock);
    chk("lu_r0_hazard", int'(a_hz), 0);
    next_cyc();
    set_lu(1'b0, 5'd0);
    chk("lu_r0_cnt", int'(a_scnt), 1);

    // Branch and load-use together: flush wins
    ex_branch_taken = 1'b1;
    set_lu(1'b1, 5'd5);
    @(posedge clock);
    chk("br_lu_flush", int'(a_fl), 1);
    chk("br_lu_hazard", int'(a_hz), 0);
    next_cyc();
    ex_branch_taken = 1'b0;
    @(posedge clock);
    chk("br_lu_flush2", int'(a_fl), 1);
    chk("br_lu_hazard2", int'(a_hz), 0);
    chk("br_fc1_no_extra_flush", int'(c_fl), 0);
    chk("br_fc1_hazard", int'(c_hz), 1);
    next_cyc();
    set_lu(1'b0, 5'd0);
    @(posedge clock);
    chk("br_fc2_done", int'(a_fl), 0);
    chk("br_fc3_flush3", int'(b_fl), 1);
    next_cyc();
    chk("br_a_flush_cnt", int'(a_fcnt), 2);
    chk("br_b_flush_cnt", int'(b_fcnt), 3);
    chk("br_c_flush_cnt", int'(c_fcnt), 1);
    chk("br_a_stall_cnt", int'(a_scnt), 1);
    chk("br_c_stall_cnt", int'(c_scnt), 2);
    next_cyc();

    // Back-to-back branches: second branch in the first registered flush cycle
    brs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    expa = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    expb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ex_branch_taken = brs[i];
      @(posedge clock);
      chk($sformatf("b2b_a[%0d]", i), int'(a_fl), int'(expa[i]));
      chk($sformatf("b2b_b[%0d]", i), int'(b_fl), int'(expb[i]));
      chk($sformatf("b2b_c[%0d]", i), int'(c_fl), int'(expc[i]));
      next_cyc();
    end
    chk("b2b_a_cnt", int'(a_fcnt), 5);
    chk("b2b_b_cnt", int'(b_fcnt), 7);
    chk("b2b_c_cnt", int'(c_fcnt), 3);

    // Saturation of the 2-bit counters
    for (int i = 0; i < 2; i++) begin
      set_lu(1'b1, 5'd9);
      @(posedge clock);
      chk($sformatf("sat_c_hazard[%0d]", i), int'(c_hz), 1);
      next_cyc();
      set_lu(1'b0, 5'd0);
      next_cyc();
    end
    ex_branch_taken = 1'b1;
    next_cyc();
    ex_branch_taken = 1'b0;
    repeat (3) next_cyc();
    chk("sat_c_stall", int'(c_scnt), 3);
    chk("sat_c_flush", int'(c_fcnt), 3);
    chk("sat_a_stall", int'(a_scnt), 3);
    chk("sat_a_flush", int'(a_fcnt), 7);
    chk("sat_b_flush", int'(b_fcnt), 10);

    // Clear beats a simultaneous increment
    cnt_clear = 1'b1;
    set_lu(1'b1, 5'd11);
    @(posedge clock);
    chk("clr_hazard", int'(a_hz), 1);
    next_cyc();
    cnt_clear = 1'b0;
    set_lu(1'b0, 5'd0);
    chk("clr_a_stall", int'(a_scnt), 0);
    chk("clr_c_stall", int'(c_scnt), 0);
    chk("clr_a_flush", int'(a_fcnt), 0);
    next_cyc();
    next_cyc();
    chk("clr_a_stall_hold", int'(a_scnt), 0);

    // Reset in the middle of a flush aborts it
    ex_branch_taken = 1'b1;
    next_cyc();
    ex_branch_taken = 1'b0;
    @(posedge clock);
    chk("rstmid_pre", int'(b_fl), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_flush", int'(b_fl), 0);
    chk("rstmid_b_fcnt", int'(b_fcnt), 0);
    chk("rstmid_a_fcnt", int'(a_fcnt), 0);
    next_cyc();
    reset = 1'b1;
    @(posedge clock);
    chk("rstmid_after", int'(b_fl), 0);
    chk("rstmid_after_cnt", int'(b_fcnt), 0);
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that drives the stall and flush inputs of the pipeline register wall (do_hazard, do_flush_REG1).
- Consumes the wall's stage taps: the EX tap (mREG2_*), the MEM tap (mREG3_*) and the WB tap (oREG4_*).
- Produces forwarding selects for the EX-stage operand muxes.
- Contains a small control FSM, a flush-length counter and saturating event counters for software.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles do_flush_REG1 is held after a taken branch (range 1-3).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clock  in  1  system clock; all state updates on negedge, aligned with the pipeline register wall.
- reset  in  1  asynchronous, active-low reset.
- id_ra_addr  in  5  source register A of the instruction held in REG1.
- id_rt_addr  in  5  source register T of the instruction held in REG1.
- id_uses_ra  in  1  REG1 instruction reads ra.
- id_uses_rt  in  1  REG1 instruction reads rt.
- ex_write_reg_addr  in  5  mREG2_write_reg_addr.
- ex_do_reg_write  in  1  mREG2_do_reg_write.
- ex_do_dm_read  in  1  mREG2_do_dm_read.
- ex_ra_addr  in  5  ra address of the instruction in EX.
- ex_rt_addr  in  5  rt address of the instruction in EX.
- mem_write_reg_addr  in  5  mREG3_write_reg_addr.
- mem_do_reg_write  in  1  mREG3_do_reg_write.
- wb_write_reg_addr  in  5  oREG4_write_reg_addr.
- wb_do_reg_write  in  1  oREG4_do_reg_write.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- cnt_clear  in  1  synchronous clear of both event counters.
- do_hazard  out  1  load-use stall request to the register wall.
- do_flush_REG1  out  1  flush request for REG1.
- fwd_ra_sel  out  2  EX operand A source select.
- fwd_rt_sel  out  2  EX operand T source select.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Register 0 never matches. Any compare against address 0 is false.
- Forwarding is combinational. Select encoding: 0 = regfile, 1 = MEM ALU result, 2 = WB write data, 3 = unused.
  - MEM has priority over WB.
  - A source matches a stage only if that stage's do_reg_write is 1 and its write address equals the source address.
- Load-use condition (combinational), all of the following true:
  - ex_do_dm_read = 1 and ex_do_reg_write = 1;
  - ex_write_reg_addr ≠ 0;
  - ex_write_reg_addr equals id_ra_addr with id_uses_ra = 1, or equals id_rt_addr with id_uses_rt = 1.
- FSM states: IDLE, STALL, FLUSH. Reset state is IDLE.
  - IDLE:
    - ex_branch_taken → FLUSH, flush counter loaded with FLUSH_CYCLES-1.
    - Otherwise load-use → STALL.
  - STALL: lasts exactly one cycle, then → IDLE. do_hazard is forced 0 in this cycle to guarantee forward progress. ex_branch_taken here → FLUSH.
  - FLUSH: counter decrements each cycle; at 0 → IDLE.
    - A new ex_branch_taken while in FLUSH reloads the counter and stays in FLUSH.
- Outputs:
  - do_flush_REG1 = 1 when ex_branch_taken = 1 or state = FLUSH.
  - do_hazard = load-use AND state = IDLE AND NOT do_flush_REG1. Flush always wins over stall, since the REG1 instruction is on the wrong path.
- Latency: do_hazard and the first flush cycle are asserted combinationally in the same cycle as their cause. The extra flush cycles (FLUSH_CYCLES > 1) come from registered state.
- Counters:
  - stall_count increments on each negedge where do_hazard = 1.
  - flush_count increments on each negedge where do_flush_REG1 = 1.
  - Both saturate at 2^CNT_W - 1.
  - cnt_clear has priority over increment.
- Reset (asynchronous, active-low): state = IDLE, flush counter = 0, stall_count = 0, flush_count = 0.
  - Outputs during reset: do_hazard, do_flush_REG1 and fwd_*_sel reflect only the combinational inputs; state-derived terms are 0.
  - Reset asserted mid-FLUSH aborts the flush immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_REGFILE = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2;
  - the state encodings HZ_IDLE, HZ_STALL, HZ_FLUSH;
  - REG_ADDR_W = 5.
- One sub-module, fwd_select: purely combinational, one instance per source operand.

Test Plan:
- Forwarding: ex_ra_addr = 3; MEM writes r3; WB writes r3 → fwd_ra_sel = 1. Drop MEM write → 2. Set ex_ra_addr = 0 with both stages writing r0 → 0.
- Load-use: EX load to r5; REG1 uses rt = r5 → do_hazard = 1 for exactly one cycle, stall_count = 1. The next cycle is STALL with do_hazard = 0, then IDLE.
- Load-use to r0: EX load to r0; REG1 uses r0 → do_hazard stays 0.
- Branch + load-use together: ex_branch_taken = 1 and load-use in the same cycle, FLUSH_CYCLES = 2 → do_flush_REG1 = 1 for 2 cycles, do_hazard = 0, flush_count = 2.
- Back-to-back branches: taken branch in the second FLUSH cycle (FLUSH_CYCLES = 3) → counter reloads; total flush length = 1 + 3 = 4 cycles.
- Reset and saturation:
  - Assert reset mid-FLUSH → do_flush_REG1 = 0 immediately, counters = 0.
  - Force stall_count to 16'hFFFF, apply a further stall → stays 16'hFFFF.
  - cnt_clear → 0.
